// File: rtl/gcd_driver_if.sv
// -----------------------------------------------------------------------------
// gcd_driver_if
//
// Purpose:
//    Groups every non-clock signal of the GCD feeder in one bundle. It covers
//    the operand input stream, the result output stream and the side that
//    connects to the GCD unit.
//
// Modports:
//    slave  - the gcd_driver side. It consumes operands and the GCD outputs,
//             and it produces the result stream and the GCD load controls.
//    master - the environment side (upstream source, downstream sink and the
//             GCD unit). Every direction is the mirror of the slave side.
//
// Signals:
//    in_valid / in_ready / in_a / in_b       operand stream
//    gcd_value1 / gcd_value2                 operands to GCD io_value1/2
//    gcd_loadingValues                       one-cycle load pulse to GCD
//    gcd_outputGCD / gcd_outputValid         result and valid from GCD
//    out_valid / out_ready / out_gcd         result stream
//    out_timeout                             result was aborted by the watchdog
//    done_count                              completed hand-offs, wraps
// -----------------------------------------------------------------------------
interface gcd_driver_if #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 8
);
   // Operand stream
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   // GCD unit connection
   logic [WIDTH-1:0] gcd_value1;
   logic [WIDTH-1:0] gcd_value2;
   logic             gcd_loadingValues;
   logic [WIDTH-1:0] gcd_outputGCD;
   logic             gcd_outputValid;

   // Result stream
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_gcd;
   logic             out_timeout;
   logic [CNT_W-1:0] done_count;

   modport slave (
      input  in_valid, in_a, in_b,
      input  gcd_outputGCD, gcd_outputValid,
      input  out_ready,
      output in_ready,
      output gcd_value1, gcd_value2, gcd_loadingValues,
      output out_valid, out_gcd, out_timeout, done_count
   );

   modport master (
      output in_valid, in_a, in_b,
      output gcd_outputGCD, gcd_outputValid,
      output out_ready,
      input  in_ready,
      input  gcd_value1, gcd_value2, gcd_loadingValues,
      input  out_valid, out_gcd, out_timeout, done_count
   );
endinterface : gcd_driver_if

// File: rtl/gcd_driver.sv
// -----------------------------------------------------------------------------
// gcd_driver
//
// Purpose:
//    Upstream feeder for a subtract-style GCD unit. It performs these steps:
//      1. Accept one operand pair from a ready/valid stream.
//      2. Present the pair to the GCD with a single-cycle load pulse.
//      3. Wait for io_outputValid.
//      4. Return the result on a ready/valid output stream.
//    A watchdog aborts pairs that never terminate, such as a = 0 with b != 0.
//    An aborted transaction returns out_gcd = 0 with out_timeout = 1.
//    Each completed hand-off, including timeouts, is counted in done_count.
//    The counter wraps.
//
// Parameters:
//    WIDTH   - operand/result width; equals the GCD datapath width
//    TIMEOUT - maximum WAIT cycles before abort (>= 2)
//    CNT_W   - width of done_count
//
// Ports:
//    clock   - single clock, all state updates on the rising edge
//    reset   - synchronous, active-high; also resets the attached GCD
//    bus     - gcd_driver_if.slave. It carries the operand stream, the result
//              stream and the GCD connection.
//
// Timing (accept at cycle t):
//    t+1 LOAD  : gcd_loadingValues = 1
//    t+2 WAIT  : first cycle in which gcd_outputValid is trusted
//    t+3       : earliest out_valid (b = 0)
//    One transaction at a time. in_ready is high only in IDLE.
// -----------------------------------------------------------------------------
module gcd_driver #(
   parameter int WIDTH   = 2,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic         clock,
   input  logic         reset,
   gcd_driver_if.slave  bus
);

   // ------------------------------------------------------------------------
   // Local parameters and types
   // ------------------------------------------------------------------------
   // The timer counts 0 .. TIMEOUT-1 inside WAIT, so it needs clog2(TIMEOUT) bits.
   localparam int               TMR_W    = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e           state_q,       state_d;
   logic [WIDTH-1:0] value1_q,      value1_d;
   logic [WIDTH-1:0] value2_q,      value2_d;
   logic             load_q,        load_d;
   logic [TMR_W-1:0] timer_q,       timer_d;
   logic             out_valid_q,   out_valid_d;
   logic [WIDTH-1:0] out_gcd_q,     out_gcd_d;
   logic             out_timeout_q, out_timeout_d;
   logic [CNT_W-1:0] done_count_q,  done_count_d;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // Reset is sampled on the clock edge, so a transaction that is in flight
   // is dropped without producing any output.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples the same pre-edge values regardless of statement order.
         state_q       <= S_IDLE;
         value1_q      <= '0;
         value2_q      <= '0;
         load_q        <= 1'b0;
         timer_q       <= '0;
         out_valid_q   <= 1'b0;
         out_gcd_q     <= '0;
         out_timeout_q <= 1'b0;
         done_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         value1_q      <= value1_d;
         value2_q      <= value2_d;
         load_q        <= load_d;
         timer_q       <= timer_d;
         out_valid_q   <= out_valid_d;
         out_gcd_q     <= out_gcd_d;
         out_timeout_q <= out_timeout_d;
         done_count_q  <= done_count_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a hold/default value first. A path
      // that does not assign a signal then cannot infer a latch.
      state_d       = state_q;
      value1_d      = value1_q;
      value2_d      = value2_q;
      load_d        = 1'b0;
      timer_d       = timer_q;
      out_valid_d   = out_valid_q;
      out_gcd_d     = out_gcd_q;
      out_timeout_d = out_timeout_q;
      done_count_d  = done_count_q;

      unique case (state_q)
         S_IDLE: begin
            // in_ready is 1 in this state, so in_valid alone completes the handshake.
            if (bus.in_valid) begin
               value1_d = bus.in_a;
               value2_d = bus.in_b;
               load_d   = 1'b1;      // load_q is high exactly while in LOAD
               state_d  = S_LOAD;
            end
         end

         S_LOAD: begin
            // The GCD still shows the previous result during this cycle.
            // gcd_outputValid is therefore ignored here.
            timer_d = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            // A valid result takes priority over a watchdog expiry in the same cycle.
            if (bus.gcd_outputValid) begin
               out_gcd_d     = bus.gcd_outputGCD;
               out_timeout_d = 1'b0;
               out_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else if (timer_q == TMR_LAST) begin
               out_gcd_d     = '0;
               out_timeout_d = 1'b1;
               out_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         S_RESP: begin
            // out_gcd / out_timeout hold their values until the consumer takes them.
            if (bus.out_ready) begin
               out_valid_d  = 1'b0;
               done_count_d = done_count_q + CNT_W'(1);
               state_d      = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.in_ready          = (state_q == S_IDLE);
   assign bus.gcd_value1        = value1_q;
   assign bus.gcd_value2        = value2_q;
   assign bus.gcd_loadingValues = load_q;
   assign bus.out_valid         = out_valid_q;
   assign bus.out_gcd           = out_gcd_q;
   assign bus.out_timeout       = out_timeout_q;
   assign bus.done_count        = done_count_q;

endmodule : gcd_driver
